// File: rtl/simmem_release_scheduler.sv
// Release scheduler for the simulated-memory response bank: tracks delayed requests per slot
// and raises a per-ID release enable once the oldest slot of that ID has counted down to zero.
module simmem_release_scheduler #(
    parameter int unsigned IDWidth    = 8,
    parameter int unsigned NumSlots   = 16,
    parameter int unsigned DelayWidth = 6
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [IDWidth-1:0]            in_id_i,
    input  logic [DelayWidth-1:0]         in_delay_i,
    output logic [2**IDWidth-1:0]         release_en_o,
    input  logic                          rel_valid_i,
    input  logic [IDWidth-1:0]            rel_id_i,
    output logic [$clog2(NumSlots+1)-1:0] occupancy_o,
    output logic                          err_o
);

    localparam int unsigned OccWidth = $clog2(NumSlots + 1);
    localparam int unsigned SlotIdxW = $clog2(NumSlots);

    logic [NumSlots-1:0]   valid_q;
    logic [IDWidth-1:0]    id_q    [NumSlots];
    logic [DelayWidth-1:0] count_q [NumSlots];
    logic [NumSlots-1:0]   age_q   [NumSlots];
    logic                  err_q;

    logic [NumSlots-1:0]   head;
    logic [NumSlots-1:0]   rel_match;
    logic                  rel_hit;
    logic                  alloc_fire;
    logic [SlotIdxW-1:0]   alloc_idx;
    logic [OccWidth-1:0]   occ;

    assign in_ready_o  = |(~valid_q);
    assign alloc_fire  = in_valid_i && in_ready_o;
    assign occupancy_o = occ;
    assign err_o       = err_q;

    // A slot is head-of-ID when no other live slot with the same ID is older than it.
    always_comb begin
        head = '0;
        for (int unsigned s = 0; s < NumSlots; s++) begin
            head[s] = valid_q[s];
            for (int unsigned j = 0; j < NumSlots; j++) begin
                if (j != s && valid_q[j] && id_q[j] == id_q[s] && age_q[j][s]) begin
                    head[s] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        release_en_o = '0;
        rel_match    = '0;
        for (int unsigned s = 0; s < NumSlots; s++) begin
            if (head[s] && count_q[s] == '0) begin
                release_en_o[id_q[s]] = 1'b1;
                rel_match[s] = rel_valid_i && (id_q[s] == rel_id_i);
            end
        end
        rel_hit = |rel_match;
    end

    always_comb begin
        alloc_idx = '0;
        occ       = '0;
        for (int unsigned s = NumSlots; s > 0; s--) begin
            if (!valid_q[s-1]) alloc_idx = SlotIdxW'(s - 1);
        end
        for (int unsigned s = 0; s < NumSlots; s++) begin
            occ = occ + OccWidth'(valid_q[s]);
        end
    end

    // Release clears happen after the allocation update so a same-cycle release drops
    // the age bit the new slot just recorded against the freed slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned s = 0; s < NumSlots; s++) begin
                id_q[s]    <= '0;
                count_q[s] <= '0;
                age_q[s]   <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NumSlots; s++) begin
                if (valid_q[s] && count_q[s] != '0) begin
                    count_q[s] <= count_q[s] - 1'b1;
                end
            end
            if (alloc_fire) begin
                valid_q[alloc_idx] <= 1'b1;
                id_q[alloc_idx]    <= in_id_i;
                count_q[alloc_idx] <= in_delay_i;
                age_q[alloc_idx]   <= '0;
                for (int unsigned j = 0; j < NumSlots; j++) begin
                    age_q[j][alloc_idx] <= valid_q[j];
                end
            end
            for (int unsigned s = 0; s < NumSlots; s++) begin
                if (rel_match[s]) begin
                    valid_q[s] <= 1'b0;
                    age_q[s]   <= '0;
                    for (int unsigned j = 0; j < NumSlots; j++) begin
                        age_q[j][s] <= 1'b0;
                    end
                end
            end
            if (rel_valid_i && !rel_hit) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
